// File: rtl/dmem_ctrl.sv
// Data memory controller: arbitrates CPU and debug ports onto a word-only data_mem, adds sub-word
// loads/stores (RMW for SB/SH) and alignment checks. Optional DMEM_BOUNDS_CHECK_EN flags out-of-range addresses.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [2:0]  dbg_size,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic [29:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RMW, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = debug port
  logic        last_q, last_d;     // port granted most recently, 1 = debug
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        sel_dbg;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_bad;
  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] mask;
  logic [31:0] ins;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Tie goes to the port that did not win the previous grant.
  assign sel_dbg   = dbg_req & (~cpu_req | ~last_q);
  assign req_we    = sel_dbg ? dbg_we    : cpu_we;
  assign req_size  = sel_dbg ? dbg_size  : cpu_size;
  assign req_addr  = sel_dbg ? dbg_addr  : cpu_addr;
  assign req_wdata = sel_dbg ? dbg_wdata : cpu_wdata;

  assign req_bad = (req_size == 3'b011) || (req_size[2:1] == 2'b11)
                 || (req_we && req_size[2])
                 || (req_size[1:0] == 2'b01 && req_addr[0])
                 || (req_size[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
                 || (BOUNDS_EN && (|req_addr[31:AW+2]));

  assign shamt = {addr_q[1:0], 3'b000};
  assign lane  = mem_rd >> shamt;
  assign mask  = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
  assign ins   = wdata_q << shamt;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    mem_wd  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d = sel_dbg;
          last_d  = sel_dbg;
          we_d    = req_we;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_bad;
          state_d = req_bad ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (!we_q) begin
          unique case (size_q)
            3'b000:  rdata_d = {{24{lane[7]}}, lane[7:0]};
            3'b100:  rdata_d = {24'h0, lane[7:0]};
            3'b001:  rdata_d = {{16{lane[15]}}, lane[15:0]};
            3'b101:  rdata_d = {16'h0, lane[15:0]};
            default: rdata_d = mem_rd;
          endcase
          state_d = S_RESP;
        end else if (size_q[1]) begin
          mem_we  = 1'b1;
          mem_wd  = wdata_q;
          state_d = S_RESP;
        end else begin
          buf_d   = mem_rd;
          state_d = S_RMW;
        end
      end
      S_RMW: begin
        mem_we  = 1'b1;
        mem_wd  = (buf_q & ~mask) | (ins & mask);
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = addr_q[31:2];
  assign busy      = (state_q != S_IDLE);
  assign cpu_ack   = (state_q == S_RESP) && !owner_q;
  assign dbg_ack   = (state_q == S_RESP) && owner_q;
  assign cpu_rdata = cpu_ack ? rdata_q : 32'h0;
  assign dbg_rdata = dbg_ack ? rdata_q : 32'h0;
  assign cpu_err   = cpu_ack & err_q;
  assign dbg_err   = dbg_ack & err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed accesses push expected responses, a monitor pops on each ack.
module tb_dmem_ctrl;

  logic        clk, rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [2:0]  cpu_size, dbg_size;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_ack, cpu_err, dbg_ack, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd, mem_rd;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] mem [0:255];

  dmem_ctrl #(.DEPTH_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wd;

  // Response monitor: pops one expectation per ack.
  always @(negedge clk) begin
    if (!rst && (cpu_ack || dbg_ack)) begin
      exp_t e;
      logic        p;
      logic [31:0] rd;
      logic        er;
      p  = dbg_ack;
      rd = dbg_ack ? dbg_rdata : cpu_rdata;
      er = dbg_ack ? dbg_err : cpu_err;
      checks++;
      if (cpu_ack && dbg_ack) begin
        failures++;
        $display("FAIL dual_ack: both acks high at %0t", $time);
      end else if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: port=%0d rdata=%h err=%0d with empty scoreboard", p, rd, er);
      end else begin
        e = sb_q.pop_front();
        if (p !== e.port || rd !== e.rdata || er !== e.err)  begin
          failures++;
          $display("FAIL resp: got port=%0d rdata=%h err=%0d, want port=%0d rdata=%h err=%0d",
                   p, rd, er, e.port, e.rdata, e.err);
        end
      end
    end
  end

  task automatic drive(input logic port, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic req);
    if (port) begin
      dbg_we = we; dbg_size = size; dbg_addr = addr; dbg_wdata = wdata; dbg_req = req;
    end else begin
      cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata; cpu_req = req;
    end
  endtask

  task automatic access(input string name, input logic port, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_we_n, input int exp_we_cyc);
    int lat;
    int we_n;
    int we_cyc;
    exp_t e;
    e.port = port; e.rdata = exp_rd; e.err = exp_err;
    sb_q.push_back(e);
    drive(port, we, size, addr, wdata, 1'b1);
    lat = -1; we_n = 0; we_cyc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_we) begin we_n++; we_cyc = n; end
      if (port ? dbg_ack : cpu_ack) begin lat = n; break; end
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (we_n != exp_we_n || (exp_we_n > 0 && we_cyc != exp_we_cyc)) begin
      failures++;
      $display("FAIL %s mem_we: got count=%0d cycle=%0d want count=%0d cycle=%0d",
               name, we_n, we_cyc, exp_we_n, exp_we_cyc);
    end
    @(posedge clk); #1;
    drive(port, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int ack_cyc[4];
    int nacks;
    exp_t e;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    cpu_req = 0; cpu_we = 0; cpu_size = 3'b010; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_size = 3'b010; dbg_addr = 0; dbg_wdata = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_ack, dbg_ack, mem_we, busy, cpu_err, dbg_err} !== 6'b0 || mem_addr !== 30'h0 ||
        mem_wd !== 32'h0 || cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b%b we=%b busy=%b addr=%h wd=%h want all zero",
               cpu_ack, dbg_ack, mem_we, busy, mem_addr, mem_wd);
    end
    @(posedge clk); #1 rst = 1'b0;

    access("sw40",   0, 1, 3'b010, 32'h40, 32'h11223344, 32'h0,        0, 2, 1, 1);
    access("lw40",   0, 0, 3'b010, 32'h40, 32'h0,        32'h11223344, 0, 2, 0, 0);
    access("sb41",   0, 1, 3'b000, 32'h41, 32'h123456AA, 32'h0,        0, 3, 1, 2);
    access("lw40b",  0, 0, 3'b010, 32'h40, 32'h0,        32'h1122AA44, 0, 2, 0, 0);
    access("lb41",   1, 0, 3'b000, 32'h41, 32'h0,        32'hFFFFFFAA, 0, 2, 0, 0);
    access("lbu41",  0, 0, 3'b100, 32'h41, 32'h0,        32'h000000AA, 0, 2, 0, 0);
    access("lh42",   1, 0, 3'b001, 32'h42, 32'h0,        32'h00001122, 0, 2, 0, 0);
    access("lhu40",  0, 0, 3'b101, 32'h40, 32'h0,        32'h0000AA44, 0, 2, 0, 0);
    access("lh40",   0, 0, 3'b001, 32'h40, 32'h0,        32'hFFFFAA44, 0, 2, 0, 0);
    access("lw42",   0, 0, 3'b010, 32'h42, 32'h0,        32'h0,        1, 1, 0, 0);
    access("sh43",   1, 1, 3'b001, 32'h43, 32'h1234,     32'h0,        1, 1, 0, 0);
    access("sz011",  0, 0, 3'b011, 32'h40, 32'h0,        32'h0,        1, 1, 0, 0);
    access("st_bu",  0, 1, 3'b100, 32'h40, 32'h77,       32'h0,        1, 1, 0, 0);
    access("sh42",   0, 1, 3'b001, 32'h42, 32'h9999BEEF, 32'h0,        0, 3, 1, 2);
    access("lw40c",  1, 0, 3'b010, 32'h40, 32'h0,        32'hBEEFAA44, 0, 2, 0, 0);
    access("sw44",   1, 1, 3'b010, 32'h44, 32'hCAFEF00D, 32'h0,        0, 2, 1, 1);

    // Reset lands in the RMW cycle of SH 0xBEEF @0x40: no ack, no write.
    drive(0, 1, 3'b001, 32'h40, 32'h0000BEEF, 1'b1);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    drive(0, 0, 3'b010, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_rmw_idle: busy=%b mem_we=%b want 0 0", busy, mem_we);
    end
    @(posedge clk); #1 rst = 1'b0;
    access("lw_after_rst", 0, 0, 3'b010, 32'h40, 32'h0, 32'hBEEFAA44, 0, 2, 0, 0);

    // Both ports held from reset: grants alternate starting with CPU.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      e.port  = i[0];
      e.rdata = i[0] ? 32'hCAFEF00D : 32'hBEEFAA44;
      e.err   = 1'b0;
      sb_q.push_back(e);
    end
    drive(0, 0, 3'b010, 32'h40, 32'h0, 1'b1);
    drive(1, 0, 3'b010, 32'h44, 32'h0, 1'b1);
    nacks = 0;
    for (int n = 0; n < 30 && nacks < 4; n++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) begin ack_cyc[nacks] = n; nacks++; end
    end
    @(posedge clk); #1;
    drive(0, 0, 3'b010, 32'h0, 32'h0, 1'b0);
    drive(1, 0, 3'b010, 32'h0, 32'h0, 1'b0);
    checks++;
    if (nacks != 4 || ack_cyc[0] != 2 || ack_cyc[1] != 5 || ack_cyc[2] != 8 || ack_cyc[3] != 11) begin
      failures++;
      $display("FAIL arb_timing: acks=%0d cycles=%0d,%0d,%0d,%0d want 4 at 2,5,8,11",
               nacks, ack_cyc[0], ack_cyc[1], ack_cyc[2], ack_cyc[3]);
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    access("sw400", 0, 1, 3'b010, 32'h400, 32'h55667788, 32'h0, 1, 1, 0, 0);
    access("lw0",   0, 0, 3'b010, 32'h0,   32'h0,        32'h0, 0, 2, 0, 0);
`else
    access("sw400", 0, 1, 3'b010, 32'h400, 32'h55667788, 32'h0,        0, 2, 1, 1);
    access("lw0",   0, 0, 3'b010, 32'h0,   32'h0,        32'h55667788, 0, 2, 0, 0);
`endif

    for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
